ddr_a2m_cmdgen: RTL and testbench

AXI2MBA bridge command generator. Sits directly downstream of the request buffer. Pops one AXI request (write or read) at a time from the request FIFO and splits the burst into MBA commands, each confined to one aligned MBA block. Commands go to the MBA arbiter over a valid/ready handshake.

---
 rtl/ddr_a2m_pkg.sv | 24 ++
 rtl/ddr_a2m_cmdsplit.sv | 92 +++++++++
 rtl/ddr_a2m_cmdgen.sv | 220 ++++++++++++++++++++++
 tb/tb_ddr_a2m_cmdgen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_a2m_pkg.sv
// Shared AXI2MBA bridge definitions: AXI burst encodings, command-generator FSM states
// and small helpers used by several bridge stages.
package ddr_a2m_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    localparam int unsigned REM_W = 9;

    // AXI LEN is beats-1; a burst carries up to 256 beats, hence the extra bit.
    function automatic logic [REM_W-1:0] beats_of_len(input logic [7:0] len);
        return {1'b0, len} + 9'd1;
    endfunction

endpackage

// File: rtl/ddr_a2m_cmdsplit.sv
// Combinational chunker: given the current address and remaining beats of a burst,
// returns the beat count of the next MBA command, the address following it and the wrap flag.
module ddr_a2m_cmdsplit
    import ddr_a2m_pkg::*;
#(
    parameter int P_AW   = 40,
    parameter int P_BLKW = 6
) (
    input  logic [P_AW-1:0]  addr,
    input  logic [REM_W-1:0] rem,
    input  logic [2:0]       size,
    input  logic [1:0]       burst,
    input  logic [7:0]       len,
    output logic [REM_W-1:0] n,
    output logic [P_AW-1:0]  next_addr,
    output logic             wrap
);

    localparam logic [P_AW-1:0] ZERO_A    = {P_AW{1'b0}};
    localparam logic [P_AW-1:0] ONE_A     = {{(P_AW-1){1'b0}}, 1'b1};
    localparam logic [P_AW-1:0] BLK_BYTES = ONE_A << P_BLKW;

    logic [P_AW-1:0]  size_mask_s;
    logic [P_AW-1:0]  aligned_s;
    logic [P_AW-1:0]  blk_room_s;
    logic [P_AW-1:0]  blk_lim_s;
    logic [P_AW-1:0]  cont_s;
    logic [P_AW-1:0]  cont_base_s;
    logic [P_AW-1:0]  cont_top_s;
    logic [P_AW-1:0]  cont_room_s;
    logic [P_AW-1:0]  rem_a_s;
    logic [P_AW-1:0]  lim_s;
    logic [P_AW-1:0]  step_s;
    logic [REM_W-1:0] chunk_s;

    assign size_mask_s = (ONE_A << size) - ONE_A;
    assign aligned_s   = addr & ~size_mask_s;
    assign blk_room_s  = (BLK_BYTES - (aligned_s & (BLK_BYTES - ONE_A))) >> size;
    // A beat wider than the block still has to make progress: one beat per command.
    assign blk_lim_s   = (blk_room_s == ZERO_A) ? ONE_A : blk_room_s;
    assign cont_s      = {{(P_AW-REM_W){1'b0}}, beats_of_len(len)} << size;
    assign cont_base_s = addr & ~(cont_s - ONE_A);
    assign cont_top_s  = cont_base_s + cont_s;
    assign cont_room_s = (cont_top_s - aligned_s) >> size;
    assign rem_a_s     = {{(P_AW-REM_W){1'b0}}, rem};

    // Chunk length and follow-on address per burst type.
    always_comb begin
        lim_s     = blk_lim_s;
        chunk_s   = 9'd1;
        step_s    = aligned_s;
        next_addr = addr;
        wrap      = 1'b0;
        case (burst_e'(burst))
            BURST_FIXED: begin
                chunk_s   = 9'd1;
                next_addr = addr;
            end
            BURST_WRAP: begin
                if (cont_s <= BLK_BYTES) begin
                    chunk_s   = beats_of_len(len);
                    next_addr = addr;
                    wrap      = 1'b1;
                end else begin
                    if (cont_room_s < blk_lim_s) begin
                        lim_s = cont_room_s;
                    end else begin
                        lim_s = blk_lim_s;
                    end
                    if (rem_a_s < lim_s) begin
                        chunk_s = rem;
                    end else begin
                        chunk_s = lim_s[REM_W-1:0];
                    end
                    step_s    = aligned_s + ({{(P_AW-REM_W){1'b0}}, chunk_s} << size);
                    next_addr = (step_s == cont_top_s) ? cont_base_s : step_s;
                end
            end
            default: begin
                if (rem_a_s < lim_s) begin
                    chunk_s = rem;
                end else begin
                    chunk_s = lim_s[REM_W-1:0];
                end
                step_s    = aligned_s + ({{(P_AW-REM_W){1'b0}}, chunk_s} << size);
                next_addr = step_s;
            end
        endcase
        n = chunk_s;
    end

endmodule

// File: rtl/ddr_a2m_cmdgen.sv
// AXI2MBA command generator: pops one AXI request from the show-ahead request FIFO and
// issues it as a series of block-confined MBA commands over a valid/ready handshake.
module ddr_a2m_cmdgen
    import ddr_a2m_pkg::*;
#(
    parameter int P_IW   = 8,
    parameter int P_AW   = 40,
    parameter int P_BLKW = 6
) (
    input  logic            CLK,
    input  logic            ZRESET,
    input  logic            REQ_EMPTY,
    output logic            REQ_RE,
    input  logic [P_IW-1:0] REQ_ID,
    input  logic [P_AW-1:0] REQ_ADDR,
    input  logic [7:0]      REQ_LEN,
    input  logic [2:0]      REQ_SIZE,
    input  logic [1:0]      REQ_BURST,
    input  logic            REQ_LOCK,
    input  logic            REQ_DIR,
    output logic            CMDVALID,
    input  logic            CMDREADY,
    output logic [P_IW-1:0] CMDID,
    output logic [P_AW-1:0] CMDADDR,
    output logic [7:0]      CMDBEATS,
    output logic [2:0]      CMDSIZE,
    output logic            CMDDIR,
    output logic            CMDLOCK,
    output logic            CMDWRAP,
    output logic            CMDFIRST,
    output logic            CMDLAST,
    output logic            BUSY
);

    state_e st_q, st_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [P_IW-1:0]  id_q, id_d;
    logic [P_AW-1:0]  addr_q, addr_d;
    logic [P_AW-1:0]  nxt_q, nxt_d;
    logic [7:0]       beats_q, beats_d;
    logic [2:0]       size_q, size_d;
    logic             dir_q, dir_d;
    logic             lock_q, lock_d;
    logic             wrap_q, wrap_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [1:0]       burst_q, burst_d;
    logic [7:0]       len_q, len_d;
    logic [REM_W-1:0] rem_q, rem_d;

    logic             req_re_s;
    logic             load_s;
    logic [P_AW-1:0]  sp_addr_s;
    logic [REM_W-1:0] sp_rem_s;
    logic [2:0]       sp_size_s;
    logic [1:0]       sp_burst_s;
    logic [7:0]       sp_len_s;
    logic [REM_W-1:0] sp_n_s;
    logic [P_AW-1:0]  sp_next_s;
    logic             sp_wrap_s;

    assign req_re_s = ZRESET & (st_q == ST_IDLE) & ~REQ_EMPTY;

    // Splitter sees the FIFO head while idle and the saved continuation while issuing.
    always_comb begin
        if (st_q == ST_IDLE) begin
            sp_addr_s  = REQ_ADDR;
            sp_rem_s   = beats_of_len(REQ_LEN);
            sp_size_s  = REQ_SIZE;
            sp_burst_s = REQ_BURST;
            sp_len_s   = REQ_LEN;
        end else begin
            sp_addr_s  = nxt_q;
            sp_rem_s   = rem_q;
            sp_size_s  = size_q;
            sp_burst_s = burst_q;
            sp_len_s   = len_q;
        end
    end

    ddr_a2m_cmdsplit #(
        .P_AW   (P_AW),
        .P_BLKW (P_BLKW)
    ) u_split (
        .addr      (sp_addr_s),
        .rem       (sp_rem_s),
        .size      (sp_size_s),
        .burst     (sp_burst_s),
        .len       (sp_len_s),
        .n         (sp_n_s),
        .next_addr (sp_next_s),
        .wrap      (sp_wrap_s)
    );

    // Next-state and command-register update; rem_q counts beats left after the shown command.
    always_comb begin
        st_d    = st_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        id_d    = id_q;
        addr_d  = addr_q;
        nxt_d   = nxt_q;
        beats_d = beats_q;
        size_d  = size_q;
        dir_d   = dir_q;
        lock_d  = lock_q;
        wrap_d  = wrap_q;
        first_d = first_q;
        last_d  = last_q;
        burst_d = burst_q;
        len_d   = len_q;
        rem_d   = rem_q;
        load_s  = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (req_re_s) begin
                    id_d    = REQ_ID;
                    size_d  = REQ_SIZE;
                    dir_d   = REQ_DIR;
                    lock_d  = REQ_LOCK;
                    burst_d = REQ_BURST;
                    len_d   = REQ_LEN;
                    first_d = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    load_s  = 1'b1;
                    st_d    = ST_ISSUE;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (CMDREADY) begin
                    if (rem_q == 9'd0) begin
                        st_d    = ST_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        first_d = 1'b0;
                        last_d  = 1'b0;
                        wrap_d  = 1'b0;
                    end else begin
                        first_d = 1'b0;
                        load_s  = 1'b1;
                    end
                end else begin
                    st_d = ST_ISSUE;
                end
            end
            default: begin
                st_d    = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        if (load_s) begin
            addr_d  = sp_addr_s;
            nxt_d   = sp_next_s;
            beats_d = sp_n_s[7:0] - 8'd1;
            rem_d   = sp_rem_s - sp_n_s;
            wrap_d  = sp_wrap_s;
            last_d  = (sp_rem_s == sp_n_s);
        end else begin
            rem_d = rem_d;
        end
    end

    // State and command registers; reset discards any burst in flight.
    always_ff @(posedge CLK or negedge ZRESET) begin
        if (!ZRESET) begin
            st_q    <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            id_q    <= {P_IW{1'b0}};
            addr_q  <= {P_AW{1'b0}};
            nxt_q   <= {P_AW{1'b0}};
            beats_q <= 8'd0;
            size_q  <= 3'd0;
            dir_q   <= 1'b0;
            lock_q  <= 1'b0;
            wrap_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            burst_q <= 2'd0;
            len_q   <= 8'd0;
            rem_q   <= 9'd0;
        end else begin
            st_q    <= st_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            nxt_q   <= nxt_d;
            beats_q <= beats_d;
            size_q  <= size_d;
            dir_q   <= dir_d;
            lock_q  <= lock_d;
            wrap_q  <= wrap_d;
            first_q <= first_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
        end
    end

    assign REQ_RE   = req_re_s;
    assign CMDVALID = valid_q;
    assign CMDID    = id_q;
    assign CMDADDR  = addr_q;
    assign CMDBEATS = beats_q;
    assign CMDSIZE  = size_q;
    assign CMDDIR   = dir_q;
    assign CMDLOCK  = lock_q;
    assign CMDWRAP  = wrap_q;
    assign CMDFIRST = first_q;
    assign CMDLAST  = last_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_ddr_a2m_cmdgen.sv
// Self-checking bench for ddr_a2m_cmdgen: FIFO model, command scoreboard, vector table
// and hand-written stall / back-to-back / mid-burst reset sequences.
module tb_ddr_a2m_cmdgen;
    import ddr_a2m_pkg::*;

    localparam int P_IW = 8, P_AW = 40, P_BLKW = 6;

    logic            CLK, ZRESET, REQ_EMPTY, REQ_RE, CMDVALID, CMDREADY;
    logic [P_IW-1:0] REQ_ID, CMDID;
    logic [P_AW-1:0] REQ_ADDR, CMDADDR;
    logic [7:0]      REQ_LEN, CMDBEATS;
    logic [2:0]      REQ_SIZE, CMDSIZE;
    logic [1:0]      REQ_BURST;
    logic            REQ_LOCK, REQ_DIR, CMDDIR, CMDLOCK, CMDWRAP, CMDFIRST, CMDLAST, BUSY;

    typedef struct packed {
        logic [7:0] id; logic [39:0] addr; logic [7:0] len; logic [2:0] size;
        logic [1:0] burst; logic lock; logic dir;
    } req_t;

    typedef struct packed {
        logic [7:0] id; logic [39:0] addr; logic [7:0] beats; logic [2:0] size;
        logic dir; logic lock; logic wrap; logic first; logic last;
    } cmd_t;

    typedef struct {
        req_t req; int ncmd;
        logic [39:0] a0, a1, a2; logic [7:0] b0, b1, b2; logic w;
    } vec_t;

    req_t fifo_q[$];
    cmd_t exp_q[$];
    vec_t vecs[8];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, first_hs_cyc = 0, last_hs_cyc = 0, last_burst_end_cyc = 0, re_gap = 0;
    bit ok;

    ddr_a2m_cmdgen #(.P_IW(P_IW), .P_AW(P_AW), .P_BLKW(P_BLKW)) dut (
        .CLK(CLK), .ZRESET(ZRESET), .REQ_EMPTY(REQ_EMPTY), .REQ_RE(REQ_RE),
        .REQ_ID(REQ_ID), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .REQ_SIZE(REQ_SIZE),
        .REQ_BURST(REQ_BURST), .REQ_LOCK(REQ_LOCK), .REQ_DIR(REQ_DIR),
        .CMDVALID(CMDVALID), .CMDREADY(CMDREADY), .CMDID(CMDID), .CMDADDR(CMDADDR),
        .CMDBEATS(CMDBEATS), .CMDSIZE(CMDSIZE), .CMDDIR(CMDDIR), .CMDLOCK(CMDLOCK),
        .CMDWRAP(CMDWRAP), .CMDFIRST(CMDFIRST), .CMDLAST(CMDLAST), .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Cycle counter used to measure handshake spacing.
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic req_t mkreq(input logic [7:0] id, input logic [39:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst, input logic lock,
                                   input logic dir);
        return '{id: id, addr: addr, len: len, size: size, burst: burst, lock: lock, dir: dir};
    endfunction

    function automatic vec_t mk(input req_t r, input int n, input logic [39:0] a0, input logic [7:0] b0,
                                input logic [39:0] a1, input logic [7:0] b1, input logic [39:0] a2,
                                input logic [7:0] b2, input logic w);
        return '{req: r, ncmd: n, a0: a0, a1: a1, a2: a2, b0: b0, b1: b1, b2: b2, w: w};
    endfunction

    function automatic void push_exp(input vec_t v);
        logic [39:0] ea[3];
        logic [7:0]  eb[3];
        ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2;
        eb[0] = v.b0; eb[1] = v.b1; eb[2] = v.b2;
        for (int i = 0; i < v.ncmd; i++) begin
            exp_q.push_back('{id: v.req.id, addr: ea[i], beats: eb[i], size: v.req.size, dir: v.req.dir,
                              lock: v.req.lock, wrap: v.w, first: (i == 0), last: (i == v.ncmd - 1)});
        end
    endfunction

    function automatic cmd_t cur_cmd();
        return '{id: CMDID, addr: CMDADDR, beats: CMDBEATS, size: CMDSIZE, dir: CMDDIR, lock: CMDLOCK,
                 wrap: CMDWRAP, first: CMDFIRST, last: CMDLAST};
    endfunction

    // Request FIFO model: show-ahead head, popped at the edge where REQ_RE was high.
    initial begin
        logic re;
        REQ_EMPTY = 1'b1; REQ_ID = '0; REQ_ADDR = '0; REQ_LEN = '0;
        REQ_SIZE = '0; REQ_BURST = '0; REQ_LOCK = 1'b0; REQ_DIR = 1'b0;
        forever begin
            @(negedge CLK);
            re = REQ_RE;
            if (re) re_gap = cyc - last_burst_end_cyc;
            @(posedge CLK);
            #1;
            if (re && fifo_q.size() > 0) void'(fifo_q.pop_front());
            #1;
            if (fifo_q.size() == 0) begin
                REQ_EMPTY = 1'b1; REQ_ID = '0; REQ_ADDR = '0; REQ_LEN = '0;
                REQ_SIZE = '0; REQ_BURST = '0; REQ_LOCK = 1'b0; REQ_DIR = 1'b0;
            end else begin
                REQ_EMPTY = 1'b0;
                REQ_ID = fifo_q[0].id; REQ_ADDR = fifo_q[0].addr; REQ_LEN = fifo_q[0].len;
                REQ_SIZE = fifo_q[0].size; REQ_BURST = fifo_q[0].burst;
                REQ_LOCK = fifo_q[0].lock; REQ_DIR = fifo_q[0].dir;
            end
        end
    end

    // Scoreboard: every accepted command is checked against the next expected one.
    initial begin
        cmd_t got, exp;
        forever begin
            @(negedge CLK);
            if (CMDVALID === 1'b1 && CMDREADY === 1'b1) begin
                got = cur_cmd();
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_cmd actual=%h expected=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    chk("cmd", got, exp);
                end
                if (got.first) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                if (got.last) last_burst_end_cyc = cyc;
            end
        end
    end

    task automatic wait_drain(input int max_cyc, output bit done);
        done = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge CLK);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout actual_pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t s1, s2;
        cmd_t e1;
        ZRESET   = 1'b0;
        CMDREADY = 1'b0;

        vecs[0] = mk(mkreq(8'h11, 40'h1000, 8'd7, 3'd3, 2'b01, 1'b0, 1'b1), 1,
                     40'h1000, 8'd7, 40'h0, 8'd0, 40'h0, 8'd0, 1'b0);
        vecs[1] = mk(mkreq(8'h22, 40'h1020, 8'd15, 3'd3, 2'b01, 1'b0, 1'b0), 3,
                     40'h1020, 8'd3, 40'h1040, 8'd7, 40'h1080, 8'd3, 1'b0);
        vecs[2] = mk(mkreq(8'h33, 40'h1018, 8'd3, 3'd3, 2'b10, 1'b1, 1'b1), 1,
                     40'h1018, 8'd3, 40'h0, 8'd0, 40'h0, 8'd0, 1'b1);
        vecs[3] = mk(mkreq(8'h44, 40'h1050, 8'd15, 3'd3, 2'b10, 1'b0, 1'b0), 3,
                     40'h1050, 8'd5, 40'h1000, 8'd7, 40'h1040, 8'd1, 1'b0);
        vecs[4] = mk(mkreq(8'h55, 40'h2004, 8'd2, 3'd2, 2'b00, 1'b0, 1'b1), 3,
                     40'h2004, 8'd0, 40'h2004, 8'd0, 40'h2004, 8'd0, 1'b0);
        vecs[5] = mk(mkreq(8'h66, 40'h1003, 8'd1, 3'd2, 2'b01, 1'b1, 1'b0), 1,
                     40'h1003, 8'd1, 40'h0, 8'd0, 40'h0, 8'd0, 1'b0);
        vecs[6] = mk(mkreq(8'h77, 40'h37, 8'd3, 3'd2, 2'b11, 1'b0, 1'b1), 2,
                     40'h37, 8'd2, 40'h40, 8'd0, 40'h0, 8'd0, 1'b0);
        vecs[7] = mk(mkreq(8'h78, 40'hFF_FFFF_FFF8, 8'd1, 3'd3, 2'b01, 1'b0, 1'b0), 2,
                     40'hFF_FFFF_FFF8, 8'd0, 40'h0, 8'd0, 40'h0, 8'd0, 1'b0);

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_flags", 64'({CMDVALID, REQ_RE, CMDFIRST, CMDLAST, CMDWRAP, BUSY}), 64'd0);
        chk("reset_fields", 64'(cur_cmd()), 64'd0);
        @(posedge CLK);
        #1;
        ZRESET   = 1'b1;
        CMDREADY = 1'b1;

        for (int i = 0; i < 8; i++) begin
            push_exp(vecs[i]);
            @(posedge CLK);
            #1;
            fifo_q.push_back(vecs[i].req);
            @(negedge CLK);
            chk("pop_cycle_re_valid", 64'({REQ_RE, CMDVALID}), 64'(2'b10));
            @(negedge CLK);
            chk("valid_next_cycle", 64'(CMDVALID), 64'd1);
            wait_drain(64, ok);
            if (ok) chk("back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'(vecs[i].ncmd - 1));
        end

        // Stall mid-burst for 5 cycles with a second request already queued.
        s1 = mk(mkreq(8'h88, 40'h1020, 8'd15, 3'd3, 2'b01, 1'b1, 1'b1), 3,
                40'h1020, 8'd3, 40'h1040, 8'd7, 40'h1080, 8'd3, 1'b0);
        s2 = mk(mkreq(8'h89, 40'h2000, 8'd0, 3'd3, 2'b01, 1'b0, 1'b0), 1,
                40'h2000, 8'd0, 40'h0, 8'd0, 40'h0, 8'd0, 1'b0);
        e1 = '{id: 8'h88, addr: 40'h1040, beats: 8'd7, size: 3'd3, dir: 1'b1, lock: 1'b1,
               wrap: 1'b0, first: 1'b0, last: 1'b0};
        push_exp(s1);
        push_exp(s2);
        @(posedge CLK);
        #1;
        fifo_q.push_back(s1.req);
        fifo_q.push_back(s2.req);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        CMDREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("stall_hold", 64'(cur_cmd()), 64'(e1));
            chk("stall_no_pop", 64'({CMDVALID, REQ_RE}), 64'(2'b10));
        end
        @(posedge CLK);
        #1;
        CMDREADY = 1'b1;
        wait_drain(64, ok);
        chk("second_pop_gap", 64'(re_gap), 64'd1);

        // Reset while the second command of a three-command burst is on the bus.
        s1 = mk(mkreq(8'h90, 40'h1020, 8'd15, 3'd3, 2'b01, 1'b0, 1'b0), 1,
                40'h1020, 8'd3, 40'h0, 8'd0, 40'h0, 8'd0, 1'b0);
        s1.req.len = 8'd15;
        exp_q.push_back('{id: 8'h90, addr: 40'h1020, beats: 8'd3, size: 3'd3, dir: 1'b0, lock: 1'b0,
                          wrap: 1'b0, first: 1'b1, last: 1'b0});
        s2 = mk(mkreq(8'h91, 40'h3000, 8'd0, 3'd3, 2'b01, 1'b0, 1'b1), 1,
                40'h3000, 8'd0, 40'h0, 8'd0, 40'h0, 8'd0, 1'b0);
        @(posedge CLK);
        #1;
        fifo_q.push_back(s1.req);
        fifo_q.push_back(s2.req);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        CMDREADY = 1'b0;
        @(negedge CLK);
        chk("second_cmd_shown", 64'(CMDADDR), 64'h1040);
        @(posedge CLK);
        #1;
        ZRESET = 1'b0;
        #1;
        chk("midburst_reset_flags", 64'({CMDVALID, REQ_RE, CMDFIRST, CMDLAST, CMDWRAP, BUSY}), 64'd0);
        chk("midburst_reset_fields", 64'(cur_cmd()), 64'd0);
        push_exp(s2);
        @(negedge CLK);
        chk("no_pop_in_reset", 64'(REQ_RE), 64'd0);
        @(posedge CLK);
        #1;
        ZRESET   = 1'b1;
        CMDREADY = 1'b1;
        @(negedge CLK);
        chk("pop_after_reset", 64'(REQ_RE), 64'd1);
        wait_drain(64, ok);
        repeat (4) @(negedge CLK);
        chk("fifo_empty_end", 64'(fifo_q.size()), 64'd0);
        chk("idle_end", 64'({CMDVALID, BUSY}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
